// File: rtl/onewire_responder.sv
// onewire_responder: Avalon-MM responder for a single-wire open-drain bus (presence, byte receive, byte transmit)
module onewire_responder #(
    parameter int TICKS_PER_US = 50,
    parameter int RESET_US     = 480,
    parameter int PRES_WAIT_US = 30,
    parameter int PRES_US      = 120,
    parameter int SAMPLE_US    = 30
) (
    input  logic        csi_clk,
    input  logic        csi_reset,
    input  logic [2:0]  avs_s1_address,
    input  logic        chipselect,
    input  logic        avs_s1_read,
    input  logic        avs_s1_write,
    input  logic [31:0] avs_s1_writedata,
    output logic [31:0] avs_s1_readdata,
    inout  wire         coe_bit
);
    typedef enum logic [1:0] {S_IDLE, S_SLOT, S_PRES_WAIT, S_PRES_DRIVE} state_t;

    state_t      r_state, w_next;
    logic [1:0]  r_sync;
    logic        r_line_d;
    logic [15:0] r_presc, r_us;
    logic [1:0]  r_ctrl;
    logic        r_mode_act;
    logic [7:0]  r_rx_shift, r_rx_data, r_tx_data;
    logic [2:0]  r_rx_cnt, r_tx_idx;
    logic        r_rx_valid, r_tx_busy, r_reset_seen, r_overrun;
    logic [31:0] r_readdata;
    logic        w_line, w_rise, w_fall, w_long, w_early, w_tx0, w_tick, w_restart;
    logic        w_drive, w_commit, w_rst_det;
    logic        w_wr, w_wr_st, w_rd_rx, w_rx_commit, w_byte, w_unused;

    assign w_line      = r_sync[1];
    assign w_rise      = w_line & ~r_line_d;
    assign w_fall      = ~w_line & r_line_d;
    assign w_long      = r_us >= 16'(RESET_US);
    assign w_early     = r_us < 16'(SAMPLE_US);
    assign w_tx0       = r_mode_act & r_tx_busy & ~r_tx_data[r_tx_idx];
    assign w_tick      = r_presc == 16'(TICKS_PER_US - 1);
    // Falling edges caused by our own drive (presence, tx zero) must not stretch the timing.
    assign w_restart   = (w_next != r_state) | (w_fall & (r_state == S_IDLE || r_state == S_PRES_WAIT));
    assign w_wr        = chipselect & avs_s1_write;
    assign w_wr_st     = w_wr & (avs_s1_address == 3'd2);
    assign w_rd_rx     = chipselect & avs_s1_read & (avs_s1_address == 3'd0);
    assign w_rx_commit = w_commit & ~r_mode_act;
    assign w_byte      = w_rx_commit & (r_rx_cnt == 3'd7);
    assign w_unused    = ^avs_s1_writedata[31:8];
    assign coe_bit     = w_drive ? 1'b0 : 1'bz;
    assign avs_s1_readdata = r_readdata;

    // Synchronize the bus line and keep the previous sample for edge detection.
    always_ff @(posedge csi_clk or posedge csi_reset) begin
        if (csi_reset) begin
            r_sync   <= 2'b11;
            r_line_d <= 1'b1;
        end else begin
            r_sync   <= {r_sync[0], coe_bit};
            r_line_d <= r_sync[1];
        end
    end

    // Microsecond prescaler and saturating microsecond counter since the last restart.
    always_ff @(posedge csi_clk or posedge csi_reset) begin
        if (csi_reset) begin
            r_presc <= '0;
            r_us    <= '0;
        end else if (w_restart) begin
            r_presc <= '0;
            r_us    <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_us    <= (r_us == 16'hFFFF) ? r_us : r_us + 16'd1;
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end

    // Bus state register.
    always_ff @(posedge csi_clk or posedge csi_reset) begin
        if (csi_reset) r_state <= S_IDLE;
        else           r_state <= w_next;
    end

    // Next state, line drive and slot/reset events; a rise seen while we still hold a zero is the master letting go early.
    always_comb begin
        w_next    = r_state;
        w_drive   = 1'b0;
        w_commit  = 1'b0;
        w_rst_det = 1'b0;
        if (!r_ctrl[0]) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rise && w_long) begin
                        w_next    = S_PRES_WAIT;
                        w_rst_det = 1'b1;
                    end else if (w_fall) begin
                        w_next = S_SLOT;
                    end
                end
                S_SLOT: begin
                    w_drive = w_tx0 & w_early;
                    if (w_rise && !w_drive) begin
                        w_next    = w_long ? S_PRES_WAIT : S_IDLE;
                        w_rst_det = w_long;
                        w_commit  = ~w_long;
                    end
                end
                S_PRES_WAIT: w_next = (r_us >= 16'(PRES_WAIT_US)) ? S_PRES_DRIVE : S_PRES_WAIT;
                S_PRES_DRIVE: begin
                    w_drive = 1'b1;
                    w_next  = (r_us >= 16'(PRES_US)) ? S_IDLE : S_PRES_DRIVE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Control register; the mode used by a slot is frozen while outside IDLE.
    always_ff @(posedge csi_clk or posedge csi_reset) begin
        if (csi_reset) begin
            r_ctrl     <= '0;
            r_mode_act <= 1'b0;
        end else begin
            if (w_wr && avs_s1_address == 3'd3) r_ctrl <= avs_s1_writedata[1:0];
            if (r_state == S_IDLE) r_mode_act <= r_ctrl[1];
        end
    end

    // Receive shifter (LSB first), byte completion and sticky flags; sets win over clears.
    always_ff @(posedge csi_clk or posedge csi_reset) begin
        if (csi_reset) begin
            r_rx_shift   <= '0;
            r_rx_cnt     <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_overrun    <= 1'b0;
            r_reset_seen <= 1'b0;
        end else begin
            if (w_rst_det) begin
                r_rx_cnt <= '0;
            end else if (w_rx_commit) begin
                r_rx_shift <= {w_early, r_rx_shift[7:1]};
                r_rx_cnt   <= r_rx_cnt + 3'd1;
                if (w_byte) r_rx_data <= {w_early, r_rx_shift[7:1]};
            end
            r_rx_valid   <= w_byte | (r_rx_valid & ~w_rd_rx);
            r_overrun    <= (w_byte & r_rx_valid & ~w_rd_rx) | (r_overrun & ~(w_wr_st & avs_s1_writedata[3]));
            r_reset_seen <= w_rst_det | (r_reset_seen & ~(w_wr_st & avs_s1_writedata[2]));
        end
    end

    // Transmit byte, busy flag and bit index.
    always_ff @(posedge csi_clk or posedge csi_reset) begin
        if (csi_reset) begin
            r_tx_data <= '0;
            r_tx_busy <= 1'b0;
            r_tx_idx  <= '0;
        end else if (w_wr && avs_s1_address == 3'd1 && !r_tx_busy) begin
            r_tx_data <= avs_s1_writedata[7:0];
            r_tx_busy <= 1'b1;
            r_tx_idx  <= '0;
        end else if (w_rst_det) begin
            r_tx_idx <= '0;
        end else if (w_commit && r_mode_act && r_tx_busy) begin
            r_tx_idx <= r_tx_idx + 3'd1;
            if (r_tx_idx == 3'd7) r_tx_busy <= 1'b0;
        end
    end

    // Registered read mux, refreshed every cycle.
    always_ff @(posedge csi_clk or posedge csi_reset) begin
        if (csi_reset) r_readdata <= '0;
        else r_readdata <= (avs_s1_address == 3'd0) ? {24'd0, r_rx_data} :
                           (avs_s1_address == 3'd2) ? {28'd0, r_overrun, r_reset_seen, r_tx_busy, r_rx_valid} :
                           (avs_s1_address == 3'd3) ? {30'd0, r_ctrl} : 32'd0;
    end
endmodule

// File: tb/tb_onewire_responder.sv
// tb_onewire_responder: self-checking bench driving a bus master model against onewire_responder
module tb_onewire_responder;
    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  addr = '0;
    logic        cs = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        m_low = 1'b0;
    wire         line;
    int          n_checks = 0;
    int          n_errors = 0;
    vec_t        vecs[$];
    logic [7:0]  m_data;
    logic        m_valid, m_ovr;

    assign line = m_low ? 1'b0 : 1'bz;
    pullup (line);
    always #5 clk = ~clk;

    onewire_responder #(.TICKS_PER_US(1)) dut (
        .csi_clk(clk), .csi_reset(rst), .avs_s1_address(addr), .chipselect(cs),
        .avs_s1_read(rd), .avs_s1_write(wr), .avs_s1_writedata(wdata),
        .avs_s1_readdata(rdata), .coe_bit(line)
    );

    task automatic chk(input string name, input bit ok, input longint got, input longint exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic chk_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk(name, got === exp, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        addr = a; wdata = d; cs = 1'b1; wr = 1'b1;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        addr = a; cs = 1'b1; rd = 1'b1;
        @(negedge clk);
        d = rdata; cs = 1'b0; rd = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] e);
        logic [31:0] d;
        bus_rd(a, d);
        chk_eq(name, d, e);
    endtask

    task automatic m_bit(input logic b);
        m_low = 1'b1; cyc(b ? 6 : 60);
        m_low = 1'b0; cyc(10);
    endtask

    task automatic m_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) m_bit(b[i]);
    endtask

    task automatic m_read_byte(output logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            m_low = 1'b1; cyc(1);
            m_low = 1'b0; cyc(14);
            b[i] = line;
            cyc(30);
        end
    endtask

    task automatic m_reset(input bit exp_pres, input string name);
        int first = -1;
        int last = -1;
        m_low = 1'b1; cyc(500);
        m_low = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (!line) begin
                if (first < 0) first = k;
                last = k;
            end
        end
        if (exp_pres) begin
            chk({name, "_start"}, first >= 30 && first <= 35, first, 30);
            chk({name, "_end"}, last >= 150 && last <= 156, last, 150);
        end else begin
            chk({name, "_nodrive"}, first < 0, first, -1);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  b, rb;
        cyc(3);
        rst = 1'b0;
        cyc(2);
        chk_eq("reset_readdata", rdata, 32'h0);
        chk("reset_line", line === 1'b1, line, 1);

        for (int a = 0; a < 8; a++) vecs.push_back(vec_t'{1'b0, 3'(a), 32'h0, 32'h0});
        vecs.push_back(vec_t'{1'b1, 3'd3, 32'h2, 32'h0});
        vecs.push_back(vec_t'{1'b0, 3'd3, 32'h0, 32'h2});
        vecs.push_back(vec_t'{1'b1, 3'd5, 32'hFFFFFFFF, 32'h0});
        vecs.push_back(vec_t'{1'b0, 3'd5, 32'h0, 32'h0});
        vecs.push_back(vec_t'{1'b0, 3'd3, 32'h0, 32'h2});
        vecs.push_back(vec_t'{1'b1, 3'd2, 32'hFFFFFFFF, 32'h0});
        vecs.push_back(vec_t'{1'b0, 3'd2, 32'h0, 32'h0});
        vecs.push_back(vec_t'{1'b1, 3'd3, 32'h0, 32'h0});
        vecs.push_back(vec_t'{1'b0, 3'd3, 32'h0, 32'h0});
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) bus_wr(vecs[i].addr, vecs[i].data);
            else rd_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end

        m_reset(1'b0, "dis_pres");
        m_byte(8'hFF);
        rd_chk("dis_status", 3'd2, 32'h0);
        rd_chk("dis_rxdata", 3'd0, 32'h0);

        bus_wr(3'd3, 32'h1);
        m_reset(1'b1, "pres");
        rd_chk("pres_status", 3'd2, 32'h4);
        bus_wr(3'd2, 32'h4);
        rd_chk("pres_status_clr", 3'd2, 32'h0);

        m_byte(8'hA5);
        rd_chk("rx_status_valid", 3'd2, 32'h1);
        rd_chk("rx_data", 3'd0, 32'hA5);
        rd_chk("rx_status_after", 3'd2, 32'h0);

        bus_wr(3'd3, 32'h3);
        bus_wr(3'd1, 32'h3C);
        rd_chk("tx_busy", 3'd2, 32'h2);
        bus_wr(3'd1, 32'hFF);
        for (int i = 0; i < 8; i++) begin
            m_low = 1'b1; cyc(1);
            m_low = 1'b0; cyc(14);
            rb[i] = line;
            cyc(30);
            if (i == 6) rd_chk("tx_busy_slot7", 3'd2, 32'h2);
        end
        chk_eq("tx_byte", {24'h0, rb}, 32'h3C);
        rd_chk("tx_done", 3'd2, 32'h0);

        bus_wr(3'd3, 32'h1);
        m_byte(8'h11);
        m_byte(8'h22);
        rd_chk("ovr_status", 3'd2, 32'h9);
        rd_chk("ovr_rxdata", 3'd0, 32'h22);
        bus_wr(3'd2, 32'h8);
        rd_chk("ovr_clear", 3'd2, 32'h0);

        m_bit(1'b1); m_bit(1'b0); m_bit(1'b1);
        m_reset(1'b1, "midbyte_pres");
        m_byte(8'h5A);
        rd_chk("midbyte_status", 3'd2, 32'h5);
        rd_chk("midbyte_rxdata", 3'd0, 32'h5A);
        bus_wr(3'd2, 32'h4);
        rd_chk("midbyte_clear", 3'd2, 32'h0);

        m_byte(8'h33);
        b = 8'hC4;
        for (int i = 0; i < 7; i++) m_bit(b[i]);
        m_low = 1'b1; cyc(6);
        m_low = 1'b0; cyc(2);
        bus_rd(3'd0, d);
        chk_eq("rdcomp_old", d, 32'h33);
        cyc(10);
        rd_chk("rdcomp_status", 3'd2, 32'h1);
        rd_chk("rdcomp_new", 3'd0, 32'hC4);

        m_low = 1'b1; cyc(500);
        m_low = 1'b0; cyc(2);
        bus_wr(3'd2, 32'h4);
        cyc(200);
        rd_chk("setwins_status", 3'd2, 32'h4);
        bus_wr(3'd2, 32'h4);

        m_data = 8'hC4; m_valid = 1'b0; m_ovr = 1'b0;
        for (int it = 0; it < 10; it++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                bus_wr(3'd3, 32'h1);
                m_byte(b);
                if (m_valid) m_ovr = 1'b1;
                m_valid = 1'b1;
                m_data = b;
                rd_chk("rnd_rx_status", 3'd2, {28'h0, m_ovr, 2'b00, m_valid});
                if ($urandom_range(0, 1) != 0) begin
                    rd_chk("rnd_rxdata", 3'd0, {24'h0, m_data});
                    m_valid = 1'b0;
                end
                if (m_ovr && $urandom_range(0, 1) != 0) begin
                    bus_wr(3'd2, 32'h8);
                    m_ovr = 1'b0;
                end
            end else begin
                bus_wr(3'd3, 32'h3);
                bus_wr(3'd1, {24'h0, b});
                m_read_byte(rb);
                chk_eq("rnd_tx", {24'h0, rb}, {24'h0, b});
                rd_chk("rnd_tx_status", 3'd2, {28'h0, m_ovr, 2'b00, m_valid});
            end
        end

        bus_wr(3'd3, 32'h1);
        m_low = 1'b1; cyc(500);
        m_low = 1'b0; cyc(60);
        chk("en_pres_active", line === 1'b0, line, 0);
        bus_wr(3'd3, 32'h0);
        chk("en_clear_release", line === 1'b1, line, 1);
        cyc(150);

        bus_wr(3'd3, 32'h1);
        m_low = 1'b1; cyc(500);
        m_low = 1'b0; cyc(60);
        chk("rst_pres_active", line === 1'b0, line, 0);
        rst = 1'b1;
        #1;
        chk("rst_release", line === 1'b1, line, 1);
        @(negedge clk);
        rst = 1'b0;
        cyc(2);
        rd_chk("rst_ctrl", 3'd3, 32'h0);
        rd_chk("rst_status", 3'd2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/onewire_responder.md
# onewire_responder

Device-side (responder) end of a single-wire open-drain bus, memory-mapped as an Avalon-MM slave. It sits on a `coe_bit` pad and answers a bus master: it detects reset pulses, drives presence pulses, receives bytes from master write slots and answers master read slots with a CPU-loaded byte. Standard-speed timing is derived from a microsecond prescaler. All bytes are LSB first.

## Interface
- `TICKS_PER_US`, default 50: csi_clk cycles per microsecond.
- `RESET_US`, default 480: minimum low time that counts as a bus reset.
- `PRES_WAIT_US`, default 30: delay from reset release to the start of presence.
- `PRES_US`, default 120: presence pulse length.
- `SAMPLE_US`, default 30: write-slot sample point; also read-slot hold time for a 0 bit.
- `csi_clk`  in  1  clock.
- `csi_reset`  in  1  reset, asynchronous, active-high.
- `avs_s1_address`  in  3  register select.
- `chipselect`  in  1  slave select.
- `avs_s1_read`  in  1  read strobe.
- `avs_s1_write`  in  1  write strobe.
- `avs_s1_writedata`  in  32  write data.
- `avs_s1_readdata`  out  32  registered read data.
- `coe_bit`  inout  1  bus line. The block drives only 1'b0 or 1'bZ and never drives 1.

## Operation
- The input is passed through a 2-flop synchronizer. Edge detection works on the synchronized value.
- A prescaler generates a 1 µs tick. A µs counter restarts on every detected falling edge and on every state entry.
- Registers (write strobe = `chipselect && avs_s1_write`):
  - Address 0, RXDATA (read): [7:0] last received byte. A read (`chipselect && avs_s1_read`) clears rx_valid.
  - Address 1, TXDATA (write): [7:0] byte to send. Writing sets tx_busy and the tx bit index to 0. The write is ignored while tx_busy=1.
  - Address 2, STATUS:
    - Read: bit0 rx_valid, bit1 tx_busy, bit2 reset_seen (sticky), bit3 rx_overrun (sticky).
    - Write: writing 1 to bit2 or bit3 clears that bit.
  - Address 3, CONTROL (read/write): bit0 enable, bit1 mode (0 = receive, 1 = transmit).
  - Other addresses read 0; writes to them are ignored.
- States:
  - IDLE, with enable=1:
    - Falling edge → SLOT.
    - Rising edge after a low of ≥ RESET_US → PRES_WAIT.
  - PRES_WAIT: line released, wait PRES_WAIT_US → PRES_DRIVE.
  - PRES_DRIVE: drive 0 for PRES_US, then release → IDLE.
  - SLOT, receive mode: sample the line at SAMPLE_US after the falling edge.
  - SLOT, transmit mode: if tx_busy and the current tx bit is 0, drive 0 from entry until SAMPLE_US. If the bit is 1, or tx_busy=0, do not drive.
  - SLOT exit: on the rising edge, commit the slot and go to IDLE. If the low lasted ≥ RESET_US, treat it as a reset instead (→ PRES_WAIT, no commit).
- Slot commit:
  - Receive mode: shift the sampled bit into rx_shift and increment the bit count. At 8 bits: rx_data ← rx_shift, count ← 0. If rx_valid was already 1, set rx_overrun. Then set rx_valid.
  - Transmit mode with tx_busy: increment the bit index. At 8 bits, clear tx_busy.
  - Transmit mode without tx_busy: no counting.
- Reset detection (from IDLE or SLOT): set reset_seen, clear the rx bit count (partial byte discarded) and restart the tx bit index at 0 (tx_busy kept).
- enable=0: state is forced to IDLE, the line is never driven and no slots or resets are processed. Registers stay accessible.
- A line held low indefinitely causes no action until it is released.

## Timing
- Reset values: `avs_s1_readdata`=0; `coe_bit`=Z; every register and flag is 0; state is IDLE.
- Read latency: 1 cycle. `avs_s1_readdata` is registered every cycle from the address mux.
- A read clears rx_valid on the cycle of the strobe. The readdata for that access shows the value before the clear.
- Line-to-internal latency is 2 cycles. Timing resolution is 1 µs, with drive edges landing within +1 µs / +2 cycles of nominal.
- Simultaneous events:
  - STATUS clear and a set in the same cycle: the set wins.
  - RXDATA read and byte completion in the same cycle: rx_valid stays 1 and no overrun is flagged.
- A CONTROL write during an active SLOT or PRES state takes effect on the next entry to IDLE.
- The exception is enable cleared mid-presence: the line is released immediately.

## Test plan
All scenarios use TICKS_PER_US=1.
- Presence: enable=1; master holds the line low 500 µs then releases → line low by responder from ~30 µs to ~150 µs after release; STATUS=0x4.
- Receive: mode 0; master sends 0xA5 (0 = 60 µs low, 1 = 6 µs low) → RXDATA reads 0xA5; STATUS bit0 is set before the read and clear after it.
- Transmit: mode 1; write TXDATA=0x3C; 8 master read slots (1 µs low, sampled at 15 µs) → master reads 0x3C; tx_busy clears after slot 8; writing TXDATA while busy does not change the byte.
- Overrun: receive 0x11 then 0x22 with no read → RXDATA=0x22, STATUS=0x9; writing 0x8 to STATUS clears bit3.
- Reset mid-byte: receive 3 bits, then a 500 µs reset, then 0x5A → presence is issued, RXDATA=0x5A, and the partial bits are discarded.
- Disabled: enable=0; reset pulse and slots → no drive, STATUS stays 0; after csi_reset asserted mid-presence the line is Z immediately.
